// File: rtl/counter_scheduler.sv
// rtl/counter_scheduler.sv - round-robin scheduler sharing one external counter
// Grants one requester at a time, clears the counter, runs it to that requester's length, pulses done.
module counter_scheduler #(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic               cnt_clr,
  output logic               cnt_en,
  input  logic [CW-1:0]      count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [NREQ-1:0]     r_grant;
  logic [NREQ-1:0]     r_done;
  logic [PW-1:0]       r_rr_ptr;
  logic [PW-1:0]       r_idx;
  logic [CW-1:0]       r_target;

  state_t              w_state_nxt;
  logic [NREQ-1:0]     w_grant_nxt;
  logic [NREQ-1:0]     w_done_nxt;
  logic [PW-1:0]       w_ptr_nxt;
  logic [PW-1:0]       w_idx_nxt;
  logic [CW-1:0]       w_target_nxt;
  logic                w_cnt_en;
  logic [PW:0]         w_pick_res;
  logic                w_found;
  logic [PW-1:0]       w_pick;
  logic                w_req_k;
  logic [NREQ-1:0]     w_pick_onehot;
  logic [CW-1:0]       w_pick_len;

  // Scan from the pointer downward in distance so the nearest set bit is written last and wins.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] ptr);
    logic [PW:0] res;
    int          j;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (r[j]) res = {1'b1, PW'(j)};
    end
    return res;
  endfunction

  assign w_pick_res    = rr_pick(req, r_rr_ptr);
  assign w_found       = w_pick_res[PW];
  assign w_pick        = w_pick_res[PW-1:0];
  assign w_pick_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
  assign w_pick_len    = len[int'(w_pick)*CW +: CW];
  assign w_req_k       = req[r_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_done   <= '0;
      r_rr_ptr <= '0;
      r_idx    <= '0;
      r_target <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_done   <= w_done_nxt;
      r_rr_ptr <= w_ptr_nxt;
      r_idx    <= w_idx_nxt;
      r_target <= w_target_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_done_nxt   = '0;
    w_ptr_nxt    = r_rr_ptr;
    w_idx_nxt    = r_idx;
    w_target_nxt = r_target;
    w_cnt_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt  = S_CLEAR;
          w_grant_nxt  = w_pick_onehot;
          w_target_nxt = w_pick_len;
          w_idx_nxt    = w_pick;
          w_ptr_nxt    = (w_pick == PW'(NREQ - 1)) ? '0 : w_pick + PW'(1);
        end
      end
      S_CLEAR: begin
        if (!w_req_k) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // Enable drops in the same cycle count reaches target so the counter holds exactly there.
        if (!w_req_k) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
        end else if (count == r_target) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = r_grant;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  assign grant   = r_grant;
  assign done    = r_done;
  assign busy    = (r_state != S_IDLE);
  assign cnt_clr = (r_state == S_CLEAR);
  assign cnt_en  = w_cnt_en;

endmodule

// File: tb/tb_counter_scheduler.sv
// tb/tb_counter_scheduler.sv - directed bench for counter_scheduler with a model of the shared counter
module tb_counter_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] len;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic        cnt_clr;
  logic        cnt_en;
  logic [3:0]  count = 4'd0;

  int checks = 0;
  int errors = 0;

  counter_scheduler #(.NREQ(4), .CW(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .len     (len),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .cnt_clr (cnt_clr),
    .cnt_en  (cnt_en),
    .count   (count)
  );

  always #5 clk = ~clk;

  // Shared 4-bit counter: synchronous clear, count enable, plain wrap.
  always @(posedge clk) begin
    if (cnt_clr)     count <= 4'd0;
    else if (cnt_en) count <= count + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int          n;
    int          en_cycles;
    int          ngrant;
    int          ndone;
    int          last_start;
    logic [3:0]  prev;
    logic [3:0]  exp_g;

    reset = 1'b0;
    req   = 4'b0000;
    len   = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_clr", cnt_clr, 0);
    check("rst_en", cnt_en, 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // req0, len 3; len changed to 7 after grant must be ignored
    len[3:0] = 4'd3;
    req      = 4'b0001;
    @(negedge clk);
    check("t1_grant", grant, 4'b0001);
    check("t1_clr", cnt_clr, 1);
    check("t1_en_c1", cnt_en, 0);
    check("t1_busy", busy, 1);
    len[3:0] = 4'd7;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t1_count", count, c);
      check("t1_en", cnt_en, (c != 3) ? 1 : 0);
      check("t1_clr_run", cnt_clr, 0);
      check("t1_nodone", done, 0);
    end
    @(negedge clk);
    check("t1_done", done, 4'b0001);
    check("t1_grant_done", grant, 4'b0001);
    check("t1_hold", count, 3);
    req = 4'b0000;
    @(negedge clk);
    check("t1_grant_off", grant, 0);
    check("t1_done_off", done, 0);
    check("t1_busy_off", busy, 0);

    // req1 with len 0
    len[7:4] = 4'd0;
    req      = 4'b0010;
    @(negedge clk);
    check("t2_grant", grant, 4'b0010);
    check("t2_clr", cnt_clr, 1);
    @(negedge clk);
    check("t2_count", count, 0);
    check("t2_en", cnt_en, 0);
    check("t2_nodone", done, 0);
    @(negedge clk);
    check("t2_done", done, 4'b0010);
    req = 4'b0000;
    @(negedge clk);
    check("t2_grant_off", grant, 0);

    // req1 with len 15: saturating target, no wrap
    len[7:4] = 4'd15;
    req      = 4'b0010;
    @(negedge clk);
    check("t2b_grant", grant, 4'b0010);
    en_cycles = 0;
    n = 0;
    while (done == 4'b0000 && n < 40) begin
      @(negedge clk);
      if (cnt_en) en_cycles++;
      n++;
    end
    check("t2b_timeout", (n < 40) ? 1 : 0, 1);
    check("t2b_done", done, 4'b0010);
    check("t2b_en_cycles", en_cycles, 15);
    check("t2b_latency", n, 17);
    check("t2b_count", count, 15);
    req = 4'b0000;
    @(negedge clk);
    check("t2b_grant_off", grant, 0);
    check("t2b_nowrap", count, 15);

    // Reset pointer, then all four request with len 2
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    len        = 16'h2222;
    req        = 4'b1111;
    ngrant     = 0;
    ndone      = 0;
    last_start = -100;
    prev       = 4'b0000;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      if (grant != 4'b0000 && prev == 4'b0000) begin
        exp_g = 4'b0001 << (ngrant % 4);
        check("t3_order", grant, exp_g);
        if (ngrant > 0) check("t3_period", t - last_start, 6);
        last_start = t;
        ngrant++;
      end
      if (done != 4'b0000) begin
        check("t3_done_sub", done, grant);
        ndone++;
      end
      check("t3_clr_en", (cnt_clr && cnt_en) ? 1 : 0, 0);
      prev = grant;
      if (t == 30) req = 4'b0000;
    end
    check("t3_ngrant", ngrant, 5);
    check("t3_ndone", ndone, 5);
    @(negedge clk);
    check("t3_idle", busy, 0);

    // Abort req2 at count 4 while req3 is pending
    len[11:8]  = 4'd10;
    len[15:12] = 4'd1;
    req        = 4'b1100;
    n = 0;
    while (!(grant == 4'b0100 && !cnt_clr && count == 4'd4) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t4_timeout", (n < 40) ? 1 : 0, 1);
    check("t4_en_before", cnt_en, 1);
    req = 4'b1000;
    #1;
    check("t4_en_abort", cnt_en, 0);
    @(negedge clk);
    check("t4_grant_off", grant, 0);
    check("t4_busy_off", busy, 0);
    check("t4_nodone", done, 0);
    check("t4_count_hold", count, 4);
    @(negedge clk);
    check("t4_next_grant", grant, 4'b1000);
    check("t4_next_clr", cnt_clr, 1);
    n = 0;
    while (done == 4'b0000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t4_done", done, 4'b1000);
    check("t4_done_lat", n, 3);
    req = 4'b0000;
    @(negedge clk);
    check("t4_end", grant, 0);

    // Async reset mid-run at count 5
    len[3:0] = 4'd9;
    req      = 4'b0001;
    n = 0;
    while (!(grant == 4'b0001 && !cnt_clr && count == 4'd5) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t5_timeout", (n < 40) ? 1 : 0, 1);
    reset = 1'b0;
    #1;
    check("t5_grant", grant, 0);
    check("t5_done", done, 0);
    check("t5_clr", cnt_clr, 0);
    check("t5_busy", busy, 0);
    check("t5_en", cnt_en, 0);
    @(negedge clk);
    check("t5_count_left", count, 5);
    reset = 1'b1;
    @(negedge clk);
    check("t5_regrant", grant, 4'b0001);
    check("t5_reclr", cnt_clr, 1);
    @(negedge clk);
    check("t5_restart", count, 0);
    check("t5_en_run", cnt_en, 1);
    req = 4'b0000;
    @(negedge clk);
    check("t5_abort", grant, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
